// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor: 2-bit saturating counter states
// and the values a freshly allocated BTB entry starts with.
package branch_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  localparam ctr_t CTR_RESET        = CTR_WNT;
  localparam ctr_t CTR_ALLOC_BRANCH = CTR_WT;
  localparam ctr_t CTR_ALLOC_JUMP   = CTR_ST;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter, covering
// allocation, taken/not-taken training and forced strong-taken for jumps.
module bp_sat_counter2
  import branch_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  input  logic is_jump,
  input  logic alloc,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (alloc) begin
      ctr_next = is_jump ? CTR_ALLOC_JUMP : CTR_ALLOC_BRANCH;
    end else if (taken) begin
      if (is_jump) begin
        ctr_next = CTR_ST;
      end else if (ctr != CTR_ST) begin
        ctr_next = ctr + 2'd1;
      end
    end else if (ctr != CTR_SNT) begin
      ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup for
// fetch, training from execute resolution, saturating hit/mispredict counters.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      lookup_pc,
  output logic             predict_taken,
  output logic [31:0]      predict_target,
  input  logic             update_en,
  input  logic [31:0]      update_pc,
  input  logic             update_taken,
  input  logic             update_is_jump,
  input  logic [31:0]      update_target,
  input  logic             update_mispredict,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + TAG_BITS + 1;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  ctr_t                r_ctr    [ENTRIES];
  logic [CNT_W-1:0]    r_hit_count;
  logic [CNT_W-1:0]    r_mispredict_count;

  logic [IDX_W-1:0]    w_lk_idx;
  logic [TAG_BITS-1:0] w_lk_tag;
  logic                w_lk_hit;
  logic [IDX_W-1:0]    w_up_idx;
  logic [TAG_BITS-1:0] w_up_tag;
  logic                w_up_hit;
  logic                w_write;
  ctr_t                w_ctr_next;
  logic                w_unused_pc;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[TAG_HI:TAG_LO];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign w_up_idx = update_pc[IDX_W+1:2];
  assign w_up_tag = update_pc[TAG_HI:TAG_LO];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  // A not-taken miss has nothing worth remembering, so it leaves the table alone.
  assign w_write  = update_en && (w_up_hit || update_taken);

  assign w_unused_pc = ^{update_pc[31:TAG_HI+1], update_pc[1:0]};

  always_comb begin
    predict_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    predict_target = predict_taken ? r_target[w_lk_idx] : lookup_pc + 32'd4;
  end

  bp_sat_counter2 u_ctr (
    .ctr      (r_ctr[w_up_idx]),
    .taken    (update_taken),
    .is_jump  (update_is_jump),
    .alloc    (!w_up_hit),
    .ctr_next (w_ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (w_write) begin
      r_ctr[w_up_idx] <= w_ctr_next;
      if (update_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= update_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count        <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_lk_hit && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + CNT_W'(1);
      end
      if (update_en && update_mispredict && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
    end
  end

  assign hit_count        = r_hit_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, random traffic against an
// array-based reference model, counter saturation and asynchronous reset.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_is_jump;
  logic [31:0] update_target;
  logic        update_mispredict;

  logic        pt32, pt4;
  logic [31:0] tg32, tg4;
  logic [31:0] hit32, misp32;
  logic [3:0]  hit4, misp4;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .predict_taken(pt32), .predict_target(tg32),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_is_jump(update_is_jump), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .hit_count(hit32), .mispredict_count(misp32)
  );

  branch_predictor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .predict_taken(pt4), .predict_target(tg4),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_is_jump(update_is_jump), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .hit_count(hit4), .mispredict_count(misp4)
  );

  // Reference model: 16 entries, direction counter kept as an integer 0..3.
  bit          m_valid [16];
  bit [7:0]    m_tag   [16];
  bit [31:0]   m_tgt   [16];
  int          m_ctr   [16];
  longint      m_hits, m_misp;

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit [7:0] tag_of(bit [31:0] pc);
    return 8'((pc >> 6) % 256);
  endfunction

  function automatic bit m_hit(bit [31:0] pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_hits = 0;
    m_misp = 0;
  endtask

  task automatic model_edge();
    int  ui;
    bit  uh;
    if (m_hit(lookup_pc)) m_hits++;
    if (update_en && update_mispredict) m_misp++;
    if (update_en) begin
      ui = idx_of(update_pc);
      uh = m_hit(update_pc);
      if (!uh && update_taken) begin
        m_valid[ui] = 1;
        m_tag[ui]   = tag_of(update_pc);
        m_tgt[ui]   = update_target;
        m_ctr[ui]   = update_is_jump ? 3 : 2;
      end else if (uh && update_taken) begin
        m_tgt[ui] = update_target;
        m_ctr[ui] = update_is_jump ? 3 : ((m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1);
      end else if (uh) begin
        m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(string tagname);
    bit        et;
    bit [31:0] eg;
    et = m_hit(lookup_pc) && (m_ctr[idx_of(lookup_pc)] >= 2);
    eg = et ? m_tgt[idx_of(lookup_pc)] : lookup_pc + 32'd4;
    chk({tagname, " taken"}, 32'(pt32), 32'(et));
    chk({tagname, " target"}, tg32, eg);
    chk({tagname, " taken4"}, 32'(pt4), 32'(et));
    chk({tagname, " hit_count"}, hit32, 32'(sat(m_hits, 32)));
    chk({tagname, " misp_count"}, misp32, 32'(sat(m_misp, 32)));
    chk({tagname, " hit_count4"}, 32'(hit4), 32'(sat(m_hits, 4)));
    chk({tagname, " misp_count4"}, 32'(misp4), 32'(sat(m_misp, 4)));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(bit [31:0] lk, bit en, bit [31:0] upc, bit tk, bit jp,
                        bit [31:0] tg, bit mp);
    lookup_pc = lk; update_en = en; update_pc = upc; update_taken = tk;
    update_is_jump = jp; update_target = tg; update_mispredict = mp;
  endtask

  typedef struct {
    bit [31:0] lk;
    bit        en;
    bit [31:0] upc;
    bit        tk;
    bit        jp;
    bit [31:0] tg;
    bit        mp;
    bit        exp_taken;
    bit [31:0] exp_target;
  } vec_t;

  vec_t vecs [19];

  initial begin
    // lookup  en  upd_pc  tk jp target  mp | taken target
    vecs[0]  = '{32'h100, 1, 32'h100, 1, 0, 32'h80,  1, 0, 32'h104};
    vecs[1]  = '{32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h80};
    vecs[2]  = '{32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 1, 32'h80};
    vecs[3]  = '{32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 0, 32'h104};
    vecs[4]  = '{32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 0, 32'h104};
    vecs[5]  = '{32'h100, 1, 32'h100, 1, 0, 32'h80,  0, 0, 32'h104};
    vecs[6]  = '{32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104};
    vecs[7]  = '{32'h100, 1, 32'h100, 1, 0, 32'h80,  1, 0, 32'h104};
    vecs[8]  = '{32'h100, 1, 32'h100, 1, 0, 32'h300, 0, 1, 32'h80};
    vecs[9]  = '{32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h300};
    vecs[10] = '{32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h144};
    vecs[11] = '{32'h140, 1, 32'h140, 1, 1, 32'h200, 1, 0, 32'h144};
    vecs[12] = '{32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h200};
    vecs[13] = '{32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h104};
    vecs[14] = '{32'h140, 1, 32'h140, 0, 0, 32'h0,   0, 1, 32'h200};
    vecs[15] = '{32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h200};
    vecs[16] = '{32'hFFFFFFFC, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0};
    vecs[17] = '{32'h140, 0, 32'h140, 1, 0, 32'h999, 1, 1, 32'h200};
    vecs[18] = '{32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 1, 32'h200};

    rst_n = 1'b0;
    set_in(32'h100, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("reset taken", 32'(pt32), 32'd0);
    chk("reset target", tg32, 32'h104);
    chk("reset hit_count", hit32, 32'd0);
    chk("reset misp_count", misp32, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      set_in(vecs[i].lk, vecs[i].en, vecs[i].upc, vecs[i].tk, vecs[i].jp, vecs[i].tg,
             vecs[i].mp);
      #3;
      chk($sformatf("vec%0d taken", i), 32'(pt32), 32'(vecs[i].exp_taken));
      chk($sformatf("vec%0d target", i), tg32, vecs[i].exp_target);
      chk_model($sformatf("vec%0d", i));
      clock_edge();
    end

    // Random traffic over a few aliasing indices/tags to exercise every update case.
    for (int i = 0; i < 400; i++) begin
      bit [31:0] lk, up;
      lk = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      up = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 9) == 0) lk = $urandom;
      set_in(lk, 1'($urandom_range(0, 3) != 0), up, 1'($urandom), 1'($urandom_range(0, 3) == 0),
             $urandom, 1'($urandom));
      #3;
      chk_model($sformatf("rnd%0d", i));
      clock_edge();
    end

    // Asynchronous reset between edges, with an allocating update pending.
    set_in(32'h100, 1, 32'h100, 1, 0, 32'h80, 1);
    clock_edge();
    set_in(32'h100, 1, 32'h140, 1, 1, 32'h200, 1);
    #2;
    chk("pre-reset taken", 32'(pt32), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async taken", 32'(pt32), 32'd0);
    chk("async target", tg32, 32'h104);
    chk("async hit_count", hit32, 32'd0);
    chk("async misp_count", misp32, 32'd0);
    chk("async hit_count4", 32'(hit4), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(32'h140, 0, 0, 0, 0, 0, 0);
    #3;
    chk_model("post-reset 0x140");
    chk("post-reset dropped update", 32'(pt32), 32'd0);
    clock_edge();

    // Twenty mispredict pulses on not-taken misses: the 4-bit counter pins at 15.
    for (int i = 0; i < 20; i++) begin
      set_in(32'h8, 1, 32'h40, 0, 0, 0, 1);
      #3;
      chk_model($sformatf("misp%0d", i));
      clock_edge();
    end
    set_in(32'h8, 0, 0, 0, 0, 0, 0);
    #3;
    chk("misp_count4 saturated", 32'(misp4), 32'd15);
    chk("misp_count 20", misp32, 32'd20);
    chk_model("final");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor: a direct-mapped branch target buffer with per-entry 2-bit saturating counters and performance counters. It sits beside the fetch stage. Each cycle it predicts taken/target for the fetch PC, and it learns from the branch/jump resolution produced in execute (`update_btb`, `jump_en`, `modify_pc`). It supersedes the single-bit `predictedTaken` source.

## Interface
Parameters:
- `ENTRIES`, 16: number of BTB entries; power of two, ≥2. `IDX_W = log2(ENTRIES)`.
- `TAG_BITS`, 8: tag width. Tag is `pc[IDX_W+TAG_BITS+1 : IDX_W+2]`; index is `pc[IDX_W+1:2]`.
- `CNT_W`, 32: width of each performance counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock domain.
- `lookup_pc` in 32: fetch-stage PC.
- `predict_taken` out 1: `hit && ctr[1]`.
- `predict_target` out 32: stored target when `predict_taken` is 1, else `lookup_pc + 4`.
- `update_en` in 1: a resolved branch/jump is in execute (`update_btb`).
- `update_pc` in 32: PC of the resolved instruction.
- `update_taken` in 1: resolved outcome (`jump_en`).
- `update_is_jump` in 1: instruction is JAL/JALR (unconditional).
- `update_target` in 32: resolved target (`jump_addr`).
- `update_mispredict` in 1: prediction was wrong (`modify_pc`). Only valid with `update_en`.
- `hit_count` out CNT_W: lookups that hit a valid entry with a matching tag.
- `mispredict_count` out CNT_W: `update_en && update_mispredict` events.

## Operation
- Per entry: `valid`, `tag[TAG_BITS]`, `target[32]`, `ctr[2]`. Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup is combinational from `lookup_pc` and the registered tables. `hit = valid[idx] && tag[idx] == tag(lookup_pc)`.
- Update is evaluated when `update_en` = 1, at the rising edge. Cases, checked in order:
  - Miss and `update_taken` = 0: no change.
  - Miss and `update_taken` = 1: allocate the entry, overwriting any alias. Set valid = 1 and write tag and target. `ctr` = 11 if `update_is_jump`, else 10.
  - Hit and `update_taken` = 1: write target, because JALR targets vary. `ctr` becomes 11 if `update_is_jump`, else it saturating-increments.
  - Hit and `update_taken` = 0: `ctr` saturating-decrements, saturating at 00. The entry stays valid and the target is unchanged.
- `update_en` = 0: tables are unchanged and `update_*` inputs are ignored.
- Performance counters:
  - `hit_count` increments on every cycle where `hit` = 1.
  - `mispredict_count` increments on `update_en && update_mispredict`.
  - Both saturate at all-ones and never wrap.
- Targets are stored as full 32 bits; there is no alignment masking (execute already masks JALR).

## Timing
- Reset, asynchronous and immediate:
  - All `valid` = 0, `ctr` = 01, `target` = 0, `tag` = 0.
  - Both performance counters = 0.
  - Consequently `predict_taken` = 0 and `predict_target` = `lookup_pc + 4`.
  - Reset asserted mid-operation discards an update in flight in that cycle.
- Lookup latency: 0 cycles, combinational.
- Update latency: a table write becomes visible to lookup in the cycle after the `update_en` edge.
- Same index looked up and updated in the same cycle: lookup returns the pre-update contents. There is no bypass.
- Counter increments: take effect at the edge that ends the qualifying cycle.
- `predict_target` adder: 32 bits, wraps at 0xFFFFFFFC + 4 = 0.

## Structure
- Package `branch_pkg`:
  - Counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - Reset counter value `CTR_RESET` = `CTR_WNT`.
  - Allocation values for branch and jump.
- Sub-module `bp_sat_counter2`: combinational next-state for one 2-bit counter.
  - Inputs: `ctr`, `taken`, `is_jump`, `alloc`.
  - Instantiated once, on the update index.
- Tables are flat register arrays with per-entry asynchronous reset. Do not use RAM inference.

## Test plan
All scenarios use `ENTRIES` = 16 and `TAG_BITS` = 8. PC 0x100 maps to idx 0, tag 0x04; PC 0x140 maps to idx 0, tag 0x05.
- Reset, then lookup 0x100 -> `predict_taken` = 0, `predict_target` = 0x104, both counters = 0.
- Update 0x100 taken, branch, target 0x80. Next cycle, lookup 0x100 -> taken = 1, target = 0x80, `hit_count` increments each cycle held.
- Two not-taken updates of 0x100 -> ctr goes 10 → 01 → 00. `predict_taken` = 0 after the first update and the entry stays a hit. A third not-taken update keeps ctr = 00.
- With 0x100 allocated, lookup 0x140 -> miss. A taken jump update at 0x140 with target 0x200 gives: lookup 0x140 -> taken, 0x200, ctr = 11; lookup 0x100 -> miss.
- Same-cycle lookup of 0x100 and taken update of 0x100 (target 0x300) -> that cycle shows the old target, the next cycle shows 0x300.
- With `CNT_W` = 4, apply 20 `update_mispredict` pulses -> `mispredict_count` = 15. Assert `rst_n` low between edges -> outputs return to reset values immediately.
